// File: rtl/line_fetch_pkg.sv
// Shared types, geometry constants and the pixel slice helper for the line fetch block.
package line_fetch_pkg;

  localparam int FBUFF_ADDR_WIDTH = 12;
  localparam int FBUFF_WIDTH      = 60;
  localparam int PXL_WIDTH        = 3;
  localparam int WORDS_PER_ROW    = 16;
  localparam int SRC_ROWS         = 240;
  localparam int PX_PER_WORD      = 20;
  localparam int H_SCALE          = 2;
  localparam int V_SCALE          = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  // Pixel idx of a word lives at bits [3*idx+2 : 3*idx]; idx is always < PX_PER_WORD.
  function automatic logic [PXL_WIDTH-1:0] px_slice(input logic [FBUFF_WIDTH-1:0] word,
                                                    input logic [9:0] idx);
    return PXL_WIDTH'(word >> (idx * 10'd3));
  endfunction

endpackage

// File: rtl/line_fetch_if.sv
// Frame buffer read bus: the controller is master, the frame buffer is slave.
interface line_fetch_if;
  import line_fetch_pkg::*;

  logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr;
  logic                        fbuff_ena;
  logic                        fbuff_rd_req;
  logic                        fbuff_rd_rsp;
  logic [FBUFF_WIDTH-1:0]      fbuff_data;

  modport master (
    output fbuff_addr, fbuff_ena, fbuff_rd_req,
    input  fbuff_rd_rsp, fbuff_data
  );

  modport slave (
    input  fbuff_addr, fbuff_ena, fbuff_rd_req,
    output fbuff_rd_rsp, fbuff_data
  );

endinterface

// File: rtl/line_pingpong_buf.sv
// Two-bank line store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; every bank is fully rewritten before display.
module line_pingpong_buf
  import line_fetch_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic                   wr_bank_i,
  input  logic [3:0]             wr_word_i,
  input  logic [FBUFF_WIDTH-1:0] wr_data_i,
  input  logic                   rd_bank_i,
  input  logic [3:0]             rd_word_i,
  output logic [FBUFF_WIDTH-1:0] rd_data_o
);

  logic [FBUFF_WIDTH-1:0] mem_q [2][WORDS_PER_ROW];

  // Capture one fetched frame buffer word into the selected bank slot.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_bank_i][wr_word_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_bank_i][rd_word_i];

endmodule

// File: rtl/line_fetch_ctrl.sv
// Fetches 320-px source rows into a ping-pong line buffer and replays each
// row 2x horizontally and 2x vertically as a registered 3-bit pixel stream.
module line_fetch_ctrl
  import line_fetch_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 frame_start_i,
  input  logic                 line_start_i,
  input  logic [8:0]           v_row_i,
  input  logic [9:0]           h_col_i,
  input  logic                 disp_en_i,
  line_fetch_if.master         fb,
  output logic [PXL_WIDTH-1:0] pxl_o,
  output logic                 busy_o,
  output logic                 fetch_err_o
);

  fetch_state_t state_q, state_d;
  logic [3:0]   word_cnt_q, word_cnt_d;
  logic [7:0]   src_row_q, src_row_d;
  logic         tgt_bank_q, tgt_bank_d;
  logic         active_bank_q, active_bank_d;
  logic         err_q, err_d;
  logic         rd_req_q, busy_q;
  logic [FBUFF_ADDR_WIDTH-1:0] addr_q;
  logic [PXL_WIDTH-1:0]        pxl_q, pxl_d;

  logic         even_line_s, fetch_trig_s, we_s, trig_bank_s;
  logic [7:0]   trig_row_s;
  logic [9:0]   word_full_s, idx_full_s;
  logic [FBUFF_WIDTH-1:0] rd_data_s;

  // Even display rows start a new source row; row 478 only swaps because row 239 is the last.
  assign even_line_s  = line_start_i & ~v_row_i[0];
  assign fetch_trig_s = frame_start_i | (even_line_s & (v_row_i < 9'd478));
  assign trig_row_s   = frame_start_i ? 8'd0 : (v_row_i[8:1] + 8'd1);

  // Bank swap and trigger decode; frame_start_i overrides a coincident line_start_i.
  always_comb begin
    active_bank_d = active_bank_q;
    trig_bank_s   = 1'b0;
    if (frame_start_i) begin
      active_bank_d = 1'b0;
      trig_bank_s   = 1'b0;
    end else if (even_line_s && (v_row_i != 9'd0)) begin
      active_bank_d = ~active_bank_q;
      trig_bank_s   = active_bank_q;
    end else begin
      active_bank_d = active_bank_q;
      trig_bank_s   = ~active_bank_q;
    end
  end

  // Fetch FSM next state: REQ for one cycle, WAIT until the response, 16 words per row.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    src_row_d  = src_row_q;
    tgt_bank_d = tgt_bank_q;
    we_s       = 1'b0;
    // A trigger that lands mid-fetch is dropped but remembered as an error.
    err_d      = err_q | (fetch_trig_s & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (fetch_trig_s) begin
          state_d    = REQ;
          word_cnt_d = 4'd0;
          src_row_d  = trig_row_s;
          tgt_bank_d = trig_bank_s;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (fb.fbuff_rd_rsp) begin
          we_s = ~rst_i;
          if (word_cnt_q == 4'd15) begin
            state_d = IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 4'd1;
            state_d    = REQ;
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pixel select: 40 display columns per word, each source pixel shown on 2 columns.
  assign word_full_s = h_col_i / 10'(PX_PER_WORD * H_SCALE);
  assign idx_full_s  = (h_col_i / 10'(H_SCALE)) % 10'(PX_PER_WORD);

  // Blank outside the display window and for out-of-range columns so pxl_o never goes X.
  always_comb begin
    pxl_d = 3'b000;
    if (disp_en_i && (word_full_s < 10'(WORDS_PER_ROW))) begin
      pxl_d = px_slice(rd_data_s, idx_full_s);
    end else begin
      pxl_d = 3'b000;
    end
  end

  // State, bookkeeping and registered outputs; all outputs are derived from next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      word_cnt_q    <= 4'd0;
      src_row_q     <= 8'd0;
      tgt_bank_q    <= 1'b0;
      active_bank_q <= 1'b0;
      err_q         <= 1'b0;
      rd_req_q      <= 1'b0;
      busy_q        <= 1'b0;
      addr_q        <= 12'd0;
      pxl_q         <= 3'b000;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      src_row_q     <= src_row_d;
      tgt_bank_q    <= tgt_bank_d;
      active_bank_q <= active_bank_d;
      err_q         <= err_d;
      rd_req_q      <= (state_d == REQ);
      busy_q        <= (state_d != IDLE);
      addr_q        <= {src_row_d, word_cnt_d};
      pxl_q         <= pxl_d;
    end
  end

  line_pingpong_buf u_buf (
    .clk_i     (clk_i),
    .we_i      (we_s),
    .wr_bank_i (tgt_bank_q),
    .wr_word_i (word_cnt_q),
    .wr_data_i (fb.fbuff_data),
    .rd_bank_i (active_bank_q),
    .rd_word_i (word_full_s[3:0]),
    .rd_data_o (rd_data_s)
  );

  assign fb.fbuff_addr   = addr_q;
  assign fb.fbuff_ena    = busy_q;
  assign fb.fbuff_rd_req = rd_req_q;
  assign pxl_o           = pxl_q;
  assign busy_o          = busy_q;
  assign fetch_err_o     = err_q;

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Randomized bench for line_fetch_ctrl with a frame buffer responder and a
// bank-level reference model of what each display column must show.
module tb_line_fetch_ctrl;
  import line_fetch_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i, frame_start_i, line_start_i, disp_en_i;
  logic [8:0] v_row_i;
  logic [9:0] h_col_i;
  logic [2:0] pxl_o;
  logic       busy_o, fetch_err_o;

  line_fetch_if fb ();

  line_fetch_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .frame_start_i (frame_start_i),
    .line_start_i  (line_start_i),
    .v_row_i       (v_row_i),
    .h_col_i       (h_col_i),
    .disp_en_i     (disp_en_i),
    .fb            (fb),
    .pxl_o         (pxl_o),
    .busy_o        (busy_o),
    .fetch_err_o   (fetch_err_o)
  );

  always #5 clk_i = ~clk_i;

  logic [59:0] fbmem [4096];
  logic [59:0] mbank [2][16];
  int          mactive;
  int          n_err = 0;
  int          n_chk = 0;

  // Frame buffer: answers each request with a one-cycle response two cycles later.
  logic        req_h1 = 1'b0, req_h2 = 1'b0;
  logic [11:0] addr_h1 = 12'd0, addr_h2 = 12'd0;
  initial begin
    fb.fbuff_rd_rsp = 1'b0;
    fb.fbuff_data   = 60'd0;
    forever begin
      @(posedge clk_i);
      #1;
      fb.fbuff_rd_rsp = req_h2;
      fb.fbuff_data   = fbmem[addr_h2];
      req_h2  = req_h1;
      addr_h2 = addr_h1;
      req_h1  = fb.fbuff_rd_req;
      addr_h1 = fb.fbuff_addr;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_line(input int v);
    line_start_i = 1'b1;
    v_row_i      = 9'(v);
    tick();
    line_start_i = 1'b0;
  endtask

  // Expected pixel: word h/40 of the shown bank, pixel (h/2)%20 within it.
  function automatic logic [2:0] ref_px(input int b, input int h);
    logic [59:0] w;
    w = mbank[b][h / 40];
    return 3'(w >> (3 * ((h / 2) % 20)));
  endfunction

  task automatic load_model(input int b, input int row);
    for (int w = 0; w < 16; w++) mbank[b][w] = fbmem[row * 16 + w];
  endtask

  task automatic check_px(input int h);
    h_col_i   = 10'(h);
    disp_en_i = 1'b1;
    tick();
    check_eq($sformatf("pxl_h%0d", h), {61'd0, pxl_o}, {61'd0, ref_px(mactive, h)});
  endtask

  task automatic check_pixels(input int n);
    check_px(0);
    check_px(639);
    for (int i = 0; i < n; i++) check_px(int'($urandom_range(0, 639)));
    disp_en_i = 1'b0;
  endtask

  task automatic no_req(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (fb.fbuff_rd_req || busy_o) seen++;
      tick();
    end
    check_eq("no_req", 64'(seen), 64'd0);
  endtask

  // Follows a fetch from its first busy cycle; optionally injects a trigger or stops early.
  task automatic watch_fetch(input int row, input int stop_k, input int inj_at);
    int  k, busy_cyc;
    bit  done;
    k = 0;
    busy_cyc = 0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!busy_o) begin
        done = 1'b1;
      end else begin
        busy_cyc++;
        if (fb.fbuff_rd_req) begin
          check_eq("addr", 64'(fb.fbuff_addr), 64'({row[7:0], k[3:0]}));
          check_eq("req_slot", 64'(i), 64'(3 * k));
          k++;
        end
        if (k == stop_k) return;
        line_start_i = (i == inj_at);
        v_row_i      = 9'd6;
        tick();
      end
    end
    line_start_i = 1'b0;
    check_eq("busy_cycles", 64'(busy_cyc), 64'd48);
    check_eq("req_count", 64'(k), 64'd16);
  endtask

  initial begin
    rst_i = 1'b1; frame_start_i = 1'b0; line_start_i = 1'b0;
    v_row_i = 9'd0; h_col_i = 10'd0; disp_en_i = 1'b0;
    for (int i = 0; i < 4096; i++) fbmem[i] = 60'({$urandom(), $urandom()});
    fbmem[0] = 60'h7;
    repeat (3) tick();
    check_eq("rst_pxl", 64'(pxl_o), 64'd0);
    check_eq("rst_req", 64'(fb.fbuff_rd_req), 64'd0);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_err", 64'(fetch_err_o), 64'd0);
    check_eq("rst_ena", 64'(fb.fbuff_ena), 64'd0);
    check_eq("rst_addr", 64'(fb.fbuff_addr), 64'd0);
    rst_i = 1'b0;
    tick();

    // Frame start fetches source row 0 into bank 0.
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    check_eq("ena_busy", 64'(fb.fbuff_ena), 64'd1);
    watch_fetch(0, 99, -1);
    mactive = 0;
    load_model(0, 0);

    // Pixel 0 of word 0 is 3'b111 and covers columns 0 and 1.
    h_col_i = 10'd0; disp_en_i = 1'b1; tick();
    check_eq("px_c0", 64'(pxl_o), 64'd7);
    h_col_i = 10'd1; tick();
    check_eq("px_c1", 64'(pxl_o), 64'd7);
    h_col_i = 10'd2; tick();
    check_eq("px_c2", 64'(pxl_o), 64'd0);
    h_col_i = 10'd0; disp_en_i = 1'b0; tick();
    check_eq("px_blank", 64'(pxl_o), 64'd0);
    h_col_i = 10'd700; disp_en_i = 1'b1; tick();
    check_eq("px_oob_x", 64'($isunknown(pxl_o)), 64'd0);
    check_pixels(20);

    // Row 0 prefetches source row 1 into bank 1 without swapping.
    pulse_line(0);
    watch_fetch(1, 99, -1);
    load_model(1, 1);
    check_pixels(6);
    pulse_line(1);
    no_req(10);
    check_pixels(4);

    // Row 2 swaps to bank 1 and fetches source row 2 into bank 0.
    pulse_line(2);
    mactive = 1;
    watch_fetch(2, 99, -1);
    load_model(0, 2);
    check_pixels(20);

    // Row 478 swaps back without fetching.
    pulse_line(478);
    mactive = 0;
    no_req(10);
    check_pixels(10);

    // A trigger during a fetch raises the sticky error; the fetch still completes.
    pulse_line(4);
    watch_fetch(3, 99, 10);
    load_model(0, 3);
    check_eq("err_set", 64'(fetch_err_o), 64'd1);
    repeat (20) tick();
    check_eq("err_sticky", 64'(fetch_err_o), 64'd1);

    // Reset in WAIT of word 5 of a new row-0 fetch (frame start beats line start).
    for (int w = 0; w < 16; w++) fbmem[w] = 60'({$urandom(), $urandom()});
    frame_start_i = 1'b1; line_start_i = 1'b1; v_row_i = 9'd2;
    tick();
    frame_start_i = 1'b0; line_start_i = 1'b0;
    watch_fetch(0, 6, -1);
    tick();
    rst_i = 1'b1;
    tick();
    check_eq("mid_rst_req", 64'(fb.fbuff_rd_req), 64'd0);
    check_eq("mid_rst_busy", 64'(busy_o), 64'd0);
    check_eq("mid_rst_err", 64'(fetch_err_o), 64'd0);
    rst_i = 1'b0;
    repeat (5) tick();
    mactive = 0;
    for (int w = 0; w < 5; w++) mbank[0][w] = fbmem[w];
    check_px(200);
    check_px(239);
    check_px(199);
    check_pixels(15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
